// File: rtl/execute_stage_pipe_pkg.sv
// lc3b_types: shared LC-3b execute-stage types (ALU ops, offsets, pipe FSM states).
package lc3b_types;
  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;
  typedef logic [7:0]  lc3b_offset8;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;
  typedef enum logic [1:0] {IDLE, MUL, FULL} lc3b_ex_state_t;
  localparam int SHAMT_W = 4;
endpackage

// File: rtl/execute_stage_pipe_iter_mul.sv
// iter_mul: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of the product.
module iter_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      busy_d   = cnt_q != '0;
      done_d   = cnt_q == '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign product = acc_q;
  assign done    = done_q;
endmodule

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: registered LC-3b execute stage with valid/ready handshake,
// iterative multiply and flush.
module execute_stage_pipe
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic [WIDTH-1:0] dest_out,
  input  lc3b_offset9      offset9,
  input  lc3b_offset11     offset11,
  input  lc3b_offset8      offset8,
  input  logic             bradd2mux_sel,
  input  logic             alumux_sel,
  input  logic             mul_en,
  input  lc3b_aluop        aluop,
  output logic [WIDTH-1:0] br_add_out,
  output logic [WIDTH-1:0] bradd2mux_out,
  output logic [WIDTH-1:0] alumux_out,
  output logic [WIDTH-1:0] destmux_out
);
  function automatic logic [WIDTH-1:0] sext_shl1(input logic [WIDTH-1:0] v, input int bits);
    return WIDTH'($signed(v << (WIDTH - bits)) >>> (WIDTH - bits - 1));
  endfunction
  function automatic logic [WIDTH-1:0] zext_shl1(input lc3b_offset8 o);
    return {{(WIDTH - 9){1'b0}}, o, 1'b0};
  endfunction
  lc3b_ex_state_t   state_q, state_d;
  logic [WIDTH-1:0] br_add_q, br_add_d, bradd2mux_q, bradd2mux_d;
  logic [WIDTH-1:0] alumux_q, alumux_d, destmux_q, destmux_d;
  logic [WIDTH-1:0] pend_br_q, pend_br_d, pend_b2_q, pend_b2_d, pend_dest_q, pend_dest_d;
  logic [WIDTH-1:0] br_calc, b2_calc, alu_res, alu_calc, mul_product;
  logic [SHAMT_W-1:0] sh;
  logic accept, is_mul, mul_done;
  assign in_ready  = !flush && (state_q == IDLE || (state_q == FULL && out_ready));
  assign out_valid = state_q == FULL;
  assign accept    = in_valid && in_ready;
  assign is_mul    = mul_en && !alumux_sel;
  assign sh        = sr2[SHAMT_W-1:0];
  always_comb begin
    br_calc  = pc + sext_shl1(WIDTH'(offset9), 9);
    b2_calc  = bradd2mux_sel ? sr1 : pc + sext_shl1(WIDTH'(offset11), 11);
    alu_res  = aluop == alu_add  ? sr1 + sr2 :
               aluop == alu_and  ? sr1 & sr2 :
               aluop == alu_not  ? ~sr1 :
               aluop == alu_sll  ? sr1 << sh :
               aluop == alu_srl  ? sr1 >> sh :
               aluop == alu_sra  ? WIDTH'($signed(sr1) >>> sh) : sr1;
    alu_calc = alumux_sel ? zext_shl1(offset8) : alu_res;
    state_d     = state_q;
    br_add_d    = br_add_q;
    bradd2mux_d = bradd2mux_q;
    alumux_d    = alumux_q;
    destmux_d   = destmux_q;
    pend_br_d   = pend_br_q;
    pend_b2_d   = pend_b2_q;
    pend_dest_d = pend_dest_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept && is_mul) begin
      state_d     = MUL;
      pend_br_d   = br_calc;
      pend_b2_d   = b2_calc;
      pend_dest_d = dest_out;
    end else if (accept) begin
      state_d     = FULL;
      br_add_d    = br_calc;
      bradd2mux_d = b2_calc;
      alumux_d    = alu_calc;
      destmux_d   = alu_calc[0] ? dest_out << 8 : dest_out;
    end else if (state_q == FULL && out_ready) begin
      state_d = IDLE;
    end else if (state_q == MUL && mul_done) begin
      // Whole result set is published together so a killed multiply leaves no trace.
      state_d     = FULL;
      br_add_d    = pend_br_q;
      bradd2mux_d = pend_b2_q;
      alumux_d    = mul_product;
      destmux_d   = mul_product[0] ? pend_dest_q << 8 : pend_dest_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      br_add_q    <= '0;
      bradd2mux_q <= '0;
      alumux_q    <= '0;
      destmux_q   <= '0;
      pend_br_q   <= '0;
      pend_b2_q   <= '0;
      pend_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      br_add_q    <= br_add_d;
      bradd2mux_q <= bradd2mux_d;
      alumux_q    <= alumux_d;
      destmux_q   <= destmux_d;
      pend_br_q   <= pend_br_d;
      pend_b2_q   <= pend_b2_d;
      pend_dest_q <= pend_dest_d;
    end
  end
  iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_mul),
    .abort   (flush),
    .a       (sr1),
    .b       (sr2),
    .product (mul_product),
    .done    (mul_done)
  );
  assign br_add_out    = br_add_q;
  assign bradd2mux_out = bradd2mux_q;
  assign alumux_out    = alumux_q;
  assign destmux_out   = destmux_q;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe: directed checks of results, handshake, multiply latency, flush and reset.
module tb_execute_stage_pipe;
  import lc3b_types::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic in_ready, out_valid;
  logic [15:0] pc = '0, sr1 = '0, sr2 = '0, dest_out = '0;
  lc3b_offset9 offset9 = '0;
  lc3b_offset11 offset11 = '0;
  lc3b_offset8 offset8 = '0;
  logic bradd2mux_sel = 1'b0, alumux_sel = 1'b0, mul_en = 1'b0;
  lc3b_aluop aluop = alu_add;
  logic [15:0] br_add_out, bradd2mux_out, alumux_out, destmux_out;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  execute_stage_pipe #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .pc(pc), .sr1(sr1), .sr2(sr2), .dest_out(dest_out),
    .offset9(offset9), .offset11(offset11), .offset8(offset8),
    .bradd2mux_sel(bradd2mux_sel), .alumux_sel(alumux_sel), .mul_en(mul_en), .aluop(aluop),
    .br_add_out(br_add_out), .bradd2mux_out(bradd2mux_out),
    .alumux_out(alumux_out), .destmux_out(destmux_out)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (alumux_out !== 16'h0) begin fails++; $display("FAIL reset_alumux got %h exp 0000", alumux_out); end
    tests++; if (br_add_out !== 16'h0) begin fails++; $display("FAIL reset_br_add got %h exp 0000", br_add_out); end
    tests++; if (destmux_out !== 16'h0 || bradd2mux_out !== 16'h0) begin fails++; $display("FAIL reset_dest_b2 got %h/%h exp 0000/0000", destmux_out, bradd2mux_out); end
    reset_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_add();
    pc = 16'h3000; offset9 = 9'h1FF; offset11 = 11'h004; aluop = alu_add;
    sr1 = 16'd5; sr2 = 16'd7; dest_out = 16'h00AB; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got %b exp 1", out_valid); end
    tests++; if (br_add_out !== 16'h2FFE) begin fails++; $display("FAIL add_br_add got %h exp 2ffe", br_add_out); end
    tests++; if (bradd2mux_out !== 16'h3008) begin fails++; $display("FAIL add_bradd2mux got %h exp 3008", bradd2mux_out); end
    tests++; if (alumux_out !== 16'h000C) begin fails++; $display("FAIL add_alumux got %h exp 000c", alumux_out); end
    tests++; if (destmux_out !== 16'h00AB) begin fails++; $display("FAIL add_destmux got %h exp 00ab", destmux_out); end
  endtask
  task automatic test_back_to_back();
    alumux_sel = 1'b1; offset8 = 8'h25; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
      tests++; if (out_valid !== 1'b1 || alumux_out !== 16'h000C || br_add_out !== 16'h2FFE) begin fails++; $display("FAIL hold_stable[%0d] got v=%b alu=%h br=%h exp v=1 alu=000c br=2ffe", i, out_valid, alumux_out, br_add_out); end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || alumux_out !== 16'h004A || destmux_out !== 16'h00AB) begin fails++; $display("FAIL b2b_zext25 got v=%b alu=%h dst=%h exp v=1 alu=004a dst=00ab", out_valid, alumux_out, destmux_out); end
    offset8 = 8'h80;
    step();
    tests++; if (out_valid !== 1'b1 || alumux_out !== 16'h0100 || destmux_out !== 16'h00AB) begin fails++; $display("FAIL b2b_zext80 got v=%b alu=%h dst=%h exp v=1 alu=0100 dst=00ab", out_valid, alumux_out, destmux_out); end
    alumux_sel = 1'b0; aluop = alu_pass; sr1 = 16'h0003;
    step();
    tests++; if (out_valid !== 1'b1 || alumux_out !== 16'h0003 || destmux_out !== 16'hAB00) begin fails++; $display("FAIL b2b_pass got v=%b alu=%h dst=%h exp v=1 alu=0003 dst=ab00", out_valid, alumux_out, destmux_out); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask
  task automatic test_alu_ops();
    lc3b_aluop ops[5] = '{alu_and, alu_not, alu_sll, alu_srl, alu_sra};
    logic [15:0] exp_alu[5] = '{16'h0401, 16'h7BDE, 16'h2108, 16'h1084, 16'hF084};
    logic [15:0] exp_dst[5] = '{16'h3400, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    pc = 16'h3000; offset9 = 9'h0FF; offset11 = 11'h400; bradd2mux_sel = 1'b0;
    sr1 = 16'h8421; sr2 = 16'h0F03; dest_out = 16'h1234; aluop = alu_add;
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    tests++; if (br_add_out !== 16'h31FE || bradd2mux_out !== 16'h2800) begin fails++; $display("FAIL ofs_bounds got br=%h b2=%h exp br=31fe b2=2800", br_add_out, bradd2mux_out); end
    tests++; if (alumux_out !== 16'h9324 || destmux_out !== 16'h1234) begin fails++; $display("FAIL alu_add got alu=%h dst=%h exp alu=9324 dst=1234", alumux_out, destmux_out); end
    bradd2mux_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      aluop = ops[i];
      step();
      tests++; if (out_valid !== 1'b1 || alumux_out !== exp_alu[i] || destmux_out !== exp_dst[i] || bradd2mux_out !== 16'h8421) begin fails++; $display("FAIL alu_op[%0d] got v=%b alu=%h dst=%h b2=%h exp v=1 alu=%h dst=%h b2=8421", i, out_valid, alumux_out, destmux_out, bradd2mux_out, exp_alu[i], exp_dst[i]); end
    end
    in_valid = 1'b0; bradd2mux_sel = 1'b0;
    step();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL alu_drain got %b exp 0", out_valid); end
  endtask
  task automatic test_mul();
    mul_en = 1'b1; alumux_sel = 1'b0; sr1 = 16'h0123; sr2 = 16'h0045;
    dest_out = 16'h00AB; pc = 16'h3000; offset9 = 9'h001; offset11 = 11'h000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL mul_busy[%0d] got rdy=%b v=%b exp rdy=0 v=0", i, in_ready, out_valid); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mul_early got %b exp 0", out_valid); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mul_valid got %b exp 1", out_valid); end
    tests++; if (alumux_out !== 16'h4E6F || destmux_out !== 16'hAB00) begin fails++; $display("FAIL mul_result got alu=%h dst=%h exp alu=4e6f dst=ab00", alumux_out, destmux_out); end
    tests++; if (br_add_out !== 16'h3002 || bradd2mux_out !== 16'h3000) begin fails++; $display("FAIL mul_br got br=%h b2=%h exp br=3002 b2=3000", br_add_out, bradd2mux_out); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mul_drain got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask
  task automatic test_flush();
    logic rose;
    mul_en = 1'b1; alumux_sel = 1'b0; sr1 = 16'h0003; sr2 = 16'h0005; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    flush = 1'b1; in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_mul_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    tests++; if (alumux_out !== 16'h4E6F) begin fails++; $display("FAIL flush_keep got %h exp 4e6f", alumux_out); end
    rose = 1'b0;
    repeat (20) begin step(); if (out_valid !== 1'b0) rose = 1'b1; end
    tests++; if (rose !== 1'b0) begin fails++; $display("FAIL flush_no_valid got %b exp 0", rose); end
    mul_en = 1'b0; alumux_sel = 1'b1; offset8 = 8'h11; flush = 1'b1; in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; alumux_sel = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || alumux_out !== 16'h4E6F) begin fails++; $display("FAIL flush_no_accept got v=%b alu=%h exp v=0 alu=4e6f", out_valid, alumux_out); end
  endtask
  task automatic test_async_reset();
    logic rose;
    mul_en = 1'b1; sr1 = 16'h0123; sr2 = 16'h0045; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
    tests++; if (alumux_out !== 16'h0 || destmux_out !== 16'h0 || br_add_out !== 16'h0 || bradd2mux_out !== 16'h0) begin fails++; $display("FAIL arst_outputs got %h %h %h %h exp all 0000", alumux_out, destmux_out, br_add_out, bradd2mux_out); end
    #1 reset_n = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL arst_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    rose = 1'b0;
    repeat (20) begin step(); if (out_valid !== 1'b0) rose = 1'b1; end
    tests++; if (rose !== 1'b0) begin fails++; $display("FAIL arst_no_partial got %b exp 0", rose); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_mul();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
